// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift-register sequencer: command ops, fill sources,
// register mode selects and the sequencer FSM states.
package shift_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    FILL_ZERO  = 2'b00,
    FILL_ONE   = 2'b01,
    FILL_ROT   = 2'b10,
    FILL_ARITH = 2'b11
  } fill_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_SHL  = 2'b01,
    SEL_SHR  = 2'b10,
    SEL_LOAD = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic is_shift(input op_e op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  function automatic sel_e op_to_sel(input op_e op);
    case (op)
      OP_LOAD: return SEL_LOAD;
      OP_SHL:  return SEL_SHL;
      OP_SHR:  return SEL_SHR;
      default: return SEL_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/shift_step_counter.sv
// Down-counter of remaining shift steps; counts above WIDTH saturate to WIDTH
// on load, and o_last flags the final step (value 1).
module shift_step_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] MAX_STEPS = CNT_W'(WIDTH);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_sat_val;

  assign w_sat_val = (i_load_val > MAX_STEPS) ? MAX_STEPS : i_load_val;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_sat_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for an 8-bit universal shift register: accepts one
// op over valid/ready and drives mode select, serial-in and load byte per step.
module shift_sequencer
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_fill,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  input  logic [WIDTH-1:0] sr_q,
  output logic [1:0]       sr_sel,
  output logic             sr_r,
  output logic [WIDTH-1:0] sr_i,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             shout,
  output logic [1:0]       o_dbg_state
);

  // Handshake: a command transfers on any posedge where cmd_valid && cmd_ready;
  // the requester holds cmd_valid and the payload stable until that edge.

  state_e           r_state;
  state_e           w_state_nxt;
  sel_e             r_sel;
  sel_e             w_sel_nxt;
  op_e              r_op;
  fill_e            r_fill;
  logic [WIDTH-1:0] r_data;
  logic             r_aborted;
  logic             w_aborted_nxt;

  op_e              w_cmd_op;
  logic             w_accept;
  logic             w_direct_done;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic             w_cnt_clr;
  logic             w_last;
  logic             w_in_exec;

  assign w_cmd_op      = op_e'(cmd_op);
  assign w_in_exec     = (r_state == ST_EXEC);
  assign cmd_ready     = !rst && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_accept      = cmd_valid && cmd_ready;
  assign w_direct_done = (w_cmd_op == OP_NOP) ||
                         (is_shift(w_cmd_op) && (cmd_cnt == '0));

  // LOAD reuses the step counter as a single-step operation.
  assign w_cnt_load_val = (w_cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_cnt;
  assign w_cnt_clr      = rst || (w_in_exec && abort);

  shift_step_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk        (clk),
    .i_clr      (w_cnt_clr),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_en       (w_in_exec),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sel     <= SEL_HOLD;
      r_op      <= OP_NOP;
      r_fill    <= FILL_ZERO;
      r_data    <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_aborted <= w_aborted_nxt;
      if (w_accept) begin
        r_op   <= w_cmd_op;
        r_fill <= fill_e'(cmd_fill);
        r_data <= cmd_data;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = SEL_HOLD;
    w_aborted_nxt = 1'b0;
    w_cnt_load    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (w_direct_done) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_EXEC;
            w_sel_nxt   = op_to_sel(w_cmd_op);
            w_cnt_load  = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        // The step issued in this cycle still lands; abort only stops the next one.
        if (abort) begin
          w_state_nxt   = ST_IDLE;
          w_aborted_nxt = 1'b1;
        end else if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_sel_nxt = r_sel;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sr_r  = 1'b0;
    shout = 1'b0;
    if (w_in_exec && is_shift(r_op)) begin
      shout = (r_op == OP_SHL) ? sr_q[WIDTH-1] : sr_q[0];
      case (r_fill)
        FILL_ZERO:  sr_r = 1'b0;
        FILL_ONE:   sr_r = 1'b1;
        FILL_ROT:   sr_r = (r_op == OP_SHL) ? sr_q[WIDTH-1] : sr_q[0];
        FILL_ARITH: sr_r = (r_op == OP_SHR) ? sr_q[WIDTH-1] : 1'b0;
        default:    sr_r = 1'b0;
      endcase
    end
  end

  assign sr_sel      = r_sel;
  assign sr_i        = r_data;
  assign busy        = w_in_exec;
  assign done        = (r_state == ST_DONE);
  assign aborted     = r_aborted;
  assign o_dbg_state = r_state;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Command-driven controller for the 8-bit universal shift register (modes hold / shift-left / shift-right / parallel-load). It accepts one operation at a time over a valid/ready handshake, then drives the register's 2-bit mode select, serial-in bit and parallel-load byte for the required number of cycles. It signals completion with a one-cycle pulse. It sits between the system FSM and the shift register datapath and is the only block allowed to drive the register's control inputs.

## Interface

- `WIDTH`, 8: register width; fixes the maximum shift count.
- `CNT_W`, 4: width of the shift-count field.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 2: 00 LOAD, 01 SHL, 10 SHR, 11 NOP.
- `cmd_fill` in 2: serial-in source.
  - 00 zero, 01 one.
  - 10 rotate.
  - 11 arithmetic: SHR replicates the MSB; SHL behaves as zero.
- `cmd_cnt` in CNT_W: number of shift steps.
- `cmd_data` in WIDTH: byte for LOAD.
- `abort` in 1: cancel the operation in flight.
- `sr_q` in WIDTH: current register contents (feedback).
- `sr_sel` out 2: register mode. 00 hold, 01 shift left (serial-in to bit 0), 10 shift right (serial-in to bit WIDTH-1), 11 load.
- `sr_r` out 1: register serial-in bit.
- `sr_i` out WIDTH: register parallel-load byte.
- `busy` out 1: operation executing.
- `done` out 1: one-cycle completion pulse.
- `aborted` out 1: one-cycle abort pulse.
- `shout` out 1: bit leaving the register on the current step (sr_q[WIDTH-1] for SHL, sr_q[0] for SHR); 0 otherwise.

## Operation

- FSM states: IDLE, EXEC, DONE.
- **IDLE**
  - `cmd_ready`=1, `sr_sel`=00.
  - On accept (`cmd_valid`&&`cmd_ready`), latch op, fill, count and data.
  - Go to EXEC, or to DONE directly if op=NOP or (op∈{SHL,SHR} and cnt=0).
- **EXEC**
  - `busy`=1, `cmd_ready`=0.
  - LOAD: one cycle with `sr_sel`=11 and `sr_i`=latched data.
  - SHL/SHR: `sr_sel`=01/10 for exactly `min(cnt, WIDTH)` cycles; counts 9–15 saturate to 8.
  - Leave to DONE when the step counter reaches 1.
- **DONE**
  - `done`=1 and `sr_sel`=00 for one cycle.
  - `cmd_ready`=1, so back-to-back commands are accepted in this cycle.
  - On accept go to EXEC/DONE exactly as from IDLE; otherwise go to IDLE.
- `sr_r` is combinational from the latched fill and op:
  - zero → 0, one → 1.
  - rotate → `sr_q[WIDTH-1]` for SHL, `sr_q[0]` for SHR.
  - arithmetic → `sr_q[WIDTH-1]` for SHR, 0 for SHL.
  - `sr_r`=0 outside EXEC.
- `sr_i` holds the last latched data; it is meaningful only while `sr_sel`=11.
- `abort`
  - Sampled in EXEC: the next cycle gives `sr_sel`=00, `aborted`=1, `done`=0, state IDLE.
  - Ignored in IDLE/DONE.
  - Steps already issued are not undone.
- Commands presented while `cmd_ready`=0 are held by the requester; they are not dropped or queued.

## Timing

- Reset: IDLE, counter 0; `sr_sel`=00, `sr_r`=0, `sr_i`=0, `busy`=0, `done`=0, `aborted`=0, `shout`=0.
  - `cmd_ready`=0 during the reset cycle, 1 from the first cycle after.
- Reset mid-EXEC: `sr_sel` returns to 00 at that edge; the remaining steps are discarded and no `done` is issued.
- `sr_sel`/`sr_i` are registered and change only after posedge. The register samples on the falling edge of the same cycle, so each EXEC cycle yields exactly one register update.
- Latency from accept edge T:
  - Steps occupy cycles T+1..T+N.
  - `done` is at T+N+1.
  - cnt=0 or NOP: `done` at T+1.
  - LOAD: step at T+1, `done` at T+2.
- Throughput: back-to-back SHL of N steps each completes every N+1 cycles.
- `abort` and the final step in the same cycle: the step completes, then `aborted` (not `done`) is pulsed.

## Structure

- Package `shift_ctrl_pkg` holds:
  - op encodings (LOAD/SHL/SHR/NOP)
  - fill encodings
  - `sr_sel` encodings (HOLD/SHL/SHR/LOAD)
  - FSM state enum
  - `WIDTH` default
- Sub-module `shift_step_counter`:
  - loads a saturated count
  - decrements while enabled
  - flags `last` at value 1
  - has synchronous clear

## Test plan

- Reset, then LOAD 0xA5 → `sr_sel`=11 for one cycle, register=0xA5, `done` 2 cycles after accept.
- Load 0x81, then SHL cnt=3 fill=rotate → three `sr_sel`=01 cycles, register=0x0C, `shout` sequence 1,0,0, `done` at T+4.
- Load 0x80, then SHR cnt=2 fill=arith → register=0xE0. Then SHR cnt=12 fill=zero → exactly 8 steps (saturation), register=0x00.
- Back-to-back SHL cnt=1 commands held valid → accepted in every DONE cycle, one `done` per 2 cycles. NOP and cnt=0 → `done` at T+1, `sr_sel` stays 00.
- Start SHL cnt=8 and assert `abort` after 3 steps → register reflects 3 shifts, `aborted`=1, `done` never asserted, `cmd_ready`=1 next cycle.
- Assert `rst` mid-EXEC → all outputs at reset values the following cycle, no `done`, register holds (`sr_sel`=00).
